// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 PWM capture path.
package motoro3_pkg;

    localparam int unsigned M3_HIGH_W = 16;
    localparam int unsigned M3_LEN_W  = 12;

    // Reported shortest pulse when the window saw no completed pulse
    localparam logic [M3_LEN_W-1:0] SHORTEST_NONE = '1;

    // One window report; field widths follow the package defaults
    typedef struct packed {
        logic [M3_HIGH_W-1:0] high;
        logic [7:0]           pulses;
        logic [M3_LEN_W-1:0]  shortest;
        logic [7:0]           shortCnt;
        logic                 ovf;
        logic [3:0]           seq;
    } m3_pwm_rpt_t;

    typedef enum logic {
        StLow,
        StHigh
    } m3_pulse_st_e;

    // 8-bit counter increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/motoro3_rpt_fifo2.sv
// Two-entry valid/ready FIFO of window reports, falling-edge clocked.
module motoro3_rpt_fifo2
    import motoro3_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic        i_push,
    input  m3_pwm_rpt_t i_data,
    input  logic        i_pop,
    output logic        o_valid,
    output logic        o_full,
    output m3_pwm_rpt_t o_head
);

    m3_pwm_rpt_t r_mem [2];
    logic        r_rdPtr;
    logic        r_wrPtr;
    logic [1:0]  r_count;
    logic        w_doPop;
    logic        w_doPush;

    // A pop frees a slot, so a push into a full FIFO is accepted in the same cycle
    assign w_doPop  = i_pop && (r_count != 2'd0);
    assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);

    // Storage, pointers and occupancy
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/motoro3_pwm_capture.sv
// Per-window PWM statistics: high time, pulse count, shortest and short pulses.
// HIGH_W and LEN_W must match the package widths used by the report struct.
module motoro3_pwm_capture
    import motoro3_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HIGH_W      = M3_HIGH_W,
    parameter int unsigned LEN_W       = M3_LEN_W
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              pwmIn,
    input  logic              winEnd,
    input  logic [LEN_W-1:0]  minPulse,
    output logic              rptValid,
    input  logic              rptReady,
    output logic [HIGH_W-1:0] rptHigh,
    output logic [7:0]        rptPulses,
    output logic [LEN_W-1:0]  rptShortest,
    output logic [7:0]        rptShort,
    output logic              rptOvf,
    output logic [3:0]        rptSeq
);

    localparam logic [HIGH_W-1:0] HIGH_MAX = '1;
    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_pwmS;
    m3_pulse_st_e           r_state;
    m3_pulse_st_e           w_stateNext;
    logic                   w_rise;
    logic                   w_fall;
    logic [LEN_W-1:0]       r_lenCnt;
    logic [HIGH_W-1:0]      r_high;
    logic [HIGH_W-1:0]      w_highNext;
    logic [7:0]             r_pulses;
    logic [7:0]             w_pulsesNext;
    logic [LEN_W-1:0]       r_shortest;
    logic [LEN_W-1:0]       w_shortestNext;
    logic [7:0]             r_short;
    logic [7:0]             w_shortNext;
    logic [3:0]             r_seq;
    logic                   r_pushPend;
    m3_pwm_rpt_t            r_snap;
    m3_pwm_rpt_t            w_pushData;
    m3_pwm_rpt_t            w_head;
    logic                   r_ovfPend;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_drop;

    // Synchronize the asynchronous PWM pin into the clk domain
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwmIn};
        end
    end

    assign w_pwmS = r_sync[SYNC_STAGES-1];

    // Pulse FSM state register
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= StLow;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Pulse FSM next state
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            StLow:   if (w_pwmS)  w_stateNext = StHigh;
            StHigh:  if (!w_pwmS) w_stateNext = StLow;
            default: w_stateNext = StLow;
        endcase
    end

    // Pulse FSM outputs: pulse start and pulse completion
    always_comb begin
        w_rise = (r_state == StLow) && w_pwmS;
        w_fall = (r_state == StHigh) && !w_pwmS;
    end

    // Pulse length counter; survives window boundaries
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_lenCnt <= '0;
        end else if (w_rise) begin
            r_lenCnt <= LEN_W'(1);
        end else if ((r_state == StHigh) && w_pwmS && (r_lenCnt != LEN_MAX)) begin
            r_lenCnt <= r_lenCnt + LEN_W'(1);
        end
    end

    // Accumulator updates for this cycle, before any window clear
    always_comb begin
        w_highNext     = r_high;
        w_pulsesNext   = r_pulses;
        w_shortestNext = r_shortest;
        w_shortNext    = r_short;
        if (w_pwmS && (r_high != HIGH_MAX)) begin
            w_highNext = r_high + HIGH_W'(1);
        end
        if (w_fall) begin
            w_pulsesNext = sat_inc8(r_pulses);
            if (r_lenCnt < r_shortest) begin
                w_shortestNext = r_lenCnt;
            end
            // minPulse of zero can never be exceeded from below
            if (r_lenCnt < minPulse) begin
                w_shortNext = sat_inc8(r_short);
            end
        end
    end

    // Window accumulators; cleared on the closing cycle
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_high     <= '0;
            r_pulses   <= '0;
            r_shortest <= SHORTEST_NONE;
            r_short    <= '0;
        end else if (winEnd) begin
            r_high     <= '0;
            r_pulses   <= '0;
            r_shortest <= SHORTEST_NONE;
            r_short    <= '0;
        end else begin
            r_high     <= w_highNext;
            r_pulses   <= w_pulsesNext;
            r_shortest <= w_shortestNext;
            r_short    <= w_shortNext;
        end
    end

    // Snapshot the closing window and stage it for the FIFO one cycle later
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pushPend <= 1'b0;
            r_snap     <= '0;
            r_seq      <= 4'd0;
        end else begin
            r_pushPend <= winEnd;
            if (winEnd) begin
                r_snap.high     <= w_highNext;
                r_snap.pulses   <= w_pulsesNext;
                r_snap.shortest <= w_shortestNext;
                r_snap.shortCnt <= w_shortNext;
                r_snap.ovf      <= 1'b0;
                r_snap.seq      <= r_seq;
                r_seq           <= r_seq + 4'd1;
            end
        end
    end

    assign w_pop  = rptValid && rptReady;
    assign w_drop = r_pushPend && w_full && !w_pop;

    // The overflow flag rides on whichever report is pushed next
    always_comb begin
        w_pushData     = r_snap;
        w_pushData.ovf = r_ovfPend;
    end

    // Remember dropped reports until a push succeeds
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            r_ovfPend <= 1'b0;
        end else if (w_drop) begin
            r_ovfPend <= 1'b1;
        end else if (r_pushPend) begin
            r_ovfPend <= 1'b0;
        end
    end

    motoro3_rpt_fifo2 u_fifo (
        .clk     (clk),
        .nRst    (nRst),
        .i_push  (r_pushPend),
        .i_data  (w_pushData),
        .i_pop   (w_pop),
        .o_valid (rptValid),
        .o_full  (w_full),
        .o_head  (w_head)
    );

    assign rptHigh     = w_head.high;
    assign rptPulses   = w_head.pulses;
    assign rptShortest = w_head.shortest;
    assign rptShort    = w_head.shortCnt;
    assign rptOvf      = w_head.ovf;
    assign rptSeq      = w_head.seq;

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Directed bench for motoro3_pwm_capture: table of single-window scenarios
// plus hand-written sequences for boundary, overflow, saturation and reset.
module tb_motoro3_pwm_capture;
    import motoro3_pkg::*;

    logic        clk = 1'b0;
    logic        nRst;
    logic        pwmIn;
    logic        winEnd;
    logic [11:0] minPulse;
    logic        rptValid;
    logic        rptReady;
    logic [15:0] rptHigh;
    logic [7:0]  rptPulses;
    logic [11:0] rptShortest;
    logic [7:0]  rptShort;
    logic        rptOvf;
    logic [3:0]  rptSeq;

    int n_checks = 0;
    int n_errors = 0;

    m3_pwm_rpt_t q[$];

    typedef struct {
        int unsigned l0;
        int unsigned l1;
        int unsigned l2;
        logic [11:0] minp;
        logic [15:0] eHigh;
        logic [7:0]  ePulses;
        logic [11:0] eShortest;
        logic [7:0]  eShort;
    } vec_t;

    vec_t vecs[5];

    always #50 clk = ~clk;

    motoro3_pwm_capture #(
        .SYNC_STAGES (2),
        .HIGH_W      (16),
        .LEN_W       (12)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .pwmIn       (pwmIn),
        .winEnd      (winEnd),
        .minPulse    (minPulse),
        .rptValid    (rptValid),
        .rptReady    (rptReady),
        .rptHigh     (rptHigh),
        .rptPulses   (rptPulses),
        .rptShortest (rptShortest),
        .rptShort    (rptShort),
        .rptOvf      (rptOvf),
        .rptSeq      (rptSeq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic m3_pwm_rpt_t cur_head();
        m3_pwm_rpt_t h;
        h.high     = rptHigh;
        h.pulses   = rptPulses;
        h.shortest = rptShortest;
        h.shortCnt = rptShort;
        h.ovf      = rptOvf;
        h.seq      = rptSeq;
        return h;
    endfunction

    // One falling edge with the given inputs; records the head if it is accepted
    task automatic cyc(input logic p, input logic w);
        pwmIn  = p;
        winEnd = w;
        if (rptValid && rptReady) q.push_back(cur_head());
        @(posedge clk);
    endtask

    task automatic run(input logic p, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(p, 1'b0);
    endtask

    task automatic do_reset();
        nRst     = 1'b0;
        pwmIn    = 1'b0;
        winEnd   = 1'b0;
        rptReady = 1'b0;
        @(posedge clk);
        @(posedge clk);
        nRst = 1'b1;
        q.delete();
    endtask

    task automatic chk_rpt(input string name, input int idx, input logic [15:0] eh,
                           input logic [7:0] ep, input logic [11:0] es, input logic [7:0] esh,
                           input logic eo, input logic [3:0] eq);
        if (idx >= q.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: report %0d missing, got %0d reports", name, idx, q.size());
        end else begin
            chk({name, ".high"}, 32'(q[idx].high), 32'(eh));
            chk({name, ".pulses"}, 32'(q[idx].pulses), 32'(ep));
            chk({name, ".shortest"}, 32'(q[idx].shortest), 32'(es));
            chk({name, ".short"}, 32'(q[idx].shortCnt), 32'(esh));
            chk({name, ".ovf"}, 32'(q[idx].ovf), 32'(eo));
            chk({name, ".seq"}, 32'(q[idx].seq), 32'(eq));
        end
    endtask

    initial begin
        // l0 l1 l2 minPulse | high pulses shortest short
        vecs[0] = '{40, 20, 5, 12'd16, 16'd65, 8'd3, 12'd5, 8'd1};
        vecs[1] = '{0, 0, 0, 12'd16, 16'd0, 8'd0, 12'hFFF, 8'd0};
        vecs[2] = '{10, 10, 10, 12'd0, 16'd30, 8'd3, 12'd10, 8'd0};
        vecs[3] = '{1, 2, 3, 12'd3, 16'd6, 8'd3, 12'd1, 8'd2};
        vecs[4] = '{16, 15, 17, 12'd16, 16'd48, 8'd3, 12'd15, 8'd1};

        minPulse = 12'd16;
        nRst     = 1'b0;
        pwmIn    = 1'b0;
        winEnd   = 1'b0;
        rptReady = 1'b0;
        @(posedge clk);
        chk("rst.valid", 32'(rptValid), 0);
        chk("rst.high", 32'(rptHigh), 0);
        chk("rst.pulses", 32'(rptPulses), 0);
        chk("rst.shortest", 32'(rptShortest), 0);
        chk("rst.short", 32'(rptShort), 0);
        chk("rst.ovf", 32'(rptOvf), 0);
        chk("rst.seq", 32'(rptSeq), 0);

        // Table: one window per row, report latency checked exactly
        do_reset();
        rptReady = 1'b1;
        for (int r = 0; r < 5; r++) begin
            minPulse = vecs[r].minp;
            run(1'b0, 5);
            run(1'b1, vecs[r].l0);
            run(1'b0, 5);
            run(1'b1, vecs[r].l1);
            run(1'b0, 5);
            run(1'b1, vecs[r].l2);
            run(1'b0, 5);
            cyc(1'b0, 1'b1);
            chk($sformatf("vec%0d.lat0", r), 32'(rptValid), 0);
            cyc(1'b0, 1'b0);
            chk($sformatf("vec%0d.lat1", r), 32'(rptValid), 1);
            cyc(1'b0, 1'b0);
            chk_rpt($sformatf("vec%0d", r), r, vecs[r].eHigh, vecs[r].ePulses,
                    vecs[r].eShortest, vecs[r].eShort, 1'b0, 4'(r));
        end

        // Pulse spanning a window boundary: 30 high cycles before, 50 after
        do_reset();
        minPulse = 12'd16;
        rptReady = 1'b1;
        for (int c = 0; c < 100; c++) cyc(c < 80, (c == 31) || (c == 90));
        run(1'b0, 3);
        chk("span.count", 32'(q.size()), 2);
        chk_rpt("span.w0", 0, 16'd30, 8'd0, 12'hFFF, 8'd0, 1'b0, 4'd0);
        chk_rpt("span.w1", 1, 16'd50, 8'd1, 12'd80, 8'd0, 1'b0, 4'd1);

        // Stalled consumer through four window closes: two kept, two dropped
        do_reset();
        for (int k = 0; k < 12; k++) cyc(1'b0, (k % 3) == 2);
        run(1'b0, 3);
        chk("ovf.stall.valid", 32'(rptValid), 1);
        chk("ovf.stall.seq", 32'(rptSeq), 0);
        rptReady = 1'b1;
        run(1'b0, 3);
        cyc(1'b0, 1'b1);
        run(1'b0, 3);
        chk("ovf.count", 32'(q.size()), 3);
        chk_rpt("ovf.r0", 0, 16'd0, 8'd0, 12'hFFF, 8'd0, 1'b0, 4'd0);
        chk_rpt("ovf.r1", 1, 16'd0, 8'd0, 12'hFFF, 8'd0, 1'b0, 4'd1);
        chk_rpt("ovf.r4", 2, 16'd0, 8'd0, 12'hFFF, 8'd0, 1'b1, 4'd4);

        // Full buffer: push and pop land on the same edge, nothing is dropped
        do_reset();
        for (int k = 0; k < 6; k++) cyc(1'b0, (k == 0) || (k == 2) || (k == 5));
        rptReady = 1'b1;
        cyc(1'b0, 1'b0);
        rptReady = 1'b0;
        run(1'b0, 2);
        chk("full.valid", 32'(rptValid), 1);
        rptReady = 1'b1;
        run(1'b0, 4);
        cyc(1'b0, 1'b1);
        run(1'b0, 3);
        chk("full.count", 32'(q.size()), 4);
        chk_rpt("full.r0", 0, 16'd0, 8'd0, 12'hFFF, 8'd0, 1'b0, 4'd0);
        chk_rpt("full.r1", 1, 16'd0, 8'd0, 12'hFFF, 8'd0, 1'b0, 4'd1);
        chk_rpt("full.r2", 2, 16'd0, 8'd0, 12'hFFF, 8'd0, 1'b0, 4'd2);
        chk_rpt("full.r3", 3, 16'd0, 8'd0, 12'hFFF, 8'd0, 1'b0, 4'd3);

        // Saturation of the high-time accumulator and the pulse length
        do_reset();
        minPulse = 12'd16;
        rptReady = 1'b1;
        run(1'b1, 70000);
        run(1'b0, 5);
        cyc(1'b0, 1'b1);
        run(1'b0, 3);
        chk("sat.count", 32'(q.size()), 1);
        chk_rpt("sat", 0, 16'hFFFF, 8'd1, 12'hFFF, 8'd0, 1'b0, 4'd0);

        // Reset mid-window with one report buffered
        do_reset();
        minPulse = 12'd16;
        run(1'b0, 3);
        run(1'b1, 7);
        run(1'b0, 5);
        cyc(1'b0, 1'b1);
        run(1'b0, 3);
        chk("rstmid.pre.valid", 32'(rptValid), 1);
        run(1'b1, 4);
        nRst  = 1'b0;
        pwmIn = 1'b0;
        #1;
        chk("rstmid.valid", 32'(rptValid), 0);
        chk("rstmid.high", 32'(rptHigh), 0);
        @(posedge clk);
        @(posedge clk);
        nRst = 1'b1;
        q.delete();
        rptReady = 1'b1;
        run(1'b0, 3);
        run(1'b1, 9);
        run(1'b0, 5);
        cyc(1'b0, 1'b1);
        run(1'b0, 3);
        chk("rstmid.count", 32'(q.size()), 1);
        chk_rpt("rstmid", 0, 16'd9, 8'd1, 12'd9, 8'd1, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/motoro3_pwm_capture.md
# motoro3_pwm_capture

Measures the PWM waveform driven toward the MOS drivers and reports per-commutation-window statistics: total high time, pulse count, shortest pulse, and count of pulses shorter than a programmable minimum. It sits beside the PWM generator in the 3-phase motor path. It closes one measurement window per window strobe, and delivers each window's report through a 2-entry valid/ready buffer to the loss-tracking and register logic.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on `pwmIn` (legal ≥ 2)
- HIGH_W, 16, width of the high-time accumulator
- LEN_W, 12, width of the pulse-length counter and `minPulse`

Ports:
- clk  in  1  10 MHz; all flops update on the falling edge
- nRst  in  1  reset nRst, asynchronous, active-low
- pwmIn  in  1  PWM as seen at the pin; asynchronous to clk
- winEnd  in  1  single-cycle strobe closing the current window
- minPulse  in  LEN_W  minimum legal high-pulse length, in clk cycles
- rptValid  out  1  head report valid
- rptReady  in  1  consumer accepts head report
- rptHigh  out  HIGH_W  sampled-high cycles in window
- rptPulses  out  8  completed high pulses in window
- rptShortest  out  LEN_W  shortest completed pulse; 0xFFF if none
- rptShort  out  8  pulses with length < `minPulse`
- rptOvf  out  1  ≥1 report dropped since the previous accepted push
- rptSeq  out  4  window sequence number

## Operation
- `pwmIn` passes through SYNC_STAGES flops, giving `pwmS`. All measurement uses `pwmS`.
- Pulse FSM:
  - LOW → HIGH when `pwmS`=1. `lenCnt` loads 1.
  - In HIGH, `lenCnt` increments, saturating at 2^LEN_W−1.
  - HIGH → LOW when `pwmS`=0. This completes a pulse of length `lenCnt`:
    - `pulses` += 1, saturating at 255
    - `shortest` = min(`shortest`, `lenCnt`)
    - if `lenCnt` < `minPulse`, `short` += 1, saturating at 255
- `highAcc` increments each cycle `pwmS`=1, saturating at 2^HIGH_W−1.
- Window close on a `winEnd` cycle:
  - Snapshot the accumulators including that cycle's update, and push the snapshot.
  - Clear `highAcc`, `pulses`, `short`. Set `shortest` = all-ones.
  - The FSM and `lenCnt` are not cleared. A pulse spanning a window boundary is counted in the window where it ends. Its high cycles are split between the two windows.
- `seq` increments on every `winEnd`, dropped windows included, and wraps 15 → 0. The pushed report carries the pre-increment value.
- Report buffer is a 2-entry FIFO:
  - Pop when `rptValid` && `rptReady`.
  - Push when full without a pop: the report is dropped and `ovfPend` is set.
  - The next successful push carries `rptOvf`=1 and clears `ovfPend`.
  - Push and pop in the same cycle when full: both occur, nothing is dropped.
  - Push and pop in the same cycle when empty: the new entry becomes head the next cycle.
- `minPulse`=0 means `rptShort` is always 0.

## Timing
- Reset values: all outputs 0. Internally, FIFO empty, FSM LOW, `shortest`=all-ones, `seq`=0, `ovfPend`=0.
- `pwmIn` to `pwmS`: SYNC_STAGES cycles. Pulses shorter than 1 cycle may be missed.
- Report latency: `winEnd` at falling edge N with buffer not full gives `rptValid`=1 after edge N+1, with head data stable.
- Head outputs hold while `rptValid`=1 and `rptReady`=0.
- `rptReady` is ignored while `rptValid`=0.
- Back-to-back `winEnd` on consecutive cycles is legal. The second window contains one cycle.
- A reset assertion mid-window discards all pending reports and accumulators immediately.

## Structure
- Package `motoro3_pkg` holds:
  - HIGH_W/LEN_W defaults
  - `m3_pwm_rpt_t` struct (high, pulses, shortest, short, ovf, seq)
  - SHORTEST_NONE = all-ones
- Sub-module `motoro3_rpt_fifo2`: generic 2-entry valid/ready FIFO of `m3_pwm_rpt_t`, with a full flag and falling-edge clocking.
- Synchronizer, FSM and accumulators stay in the top module.

## Test plan
- 100-cycle window containing pulses of 40, 20 and 5 cycles, `minPulse`=16, ready=1. Expect a report with rptHigh=65, rptPulses=3, rptShortest=5, rptShort=1, rptOvf=0, rptSeq=0.
- `pwmIn` held high across `winEnd` (30 cycles before, 50 after). Expect window 0 rptHigh=30, rptPulses=0, rptShortest=0xFFF; window 1 rptHigh=50, rptPulses=1, rptShortest=80.
- rptReady=0 through 4 `winEnd`s, then ready=1. Expect reports with rptSeq 0 and 1; rptSeq 2 and 3 dropped. The next window's report arrives with rptSeq=4 and rptOvf=1.
- Buffer full, with `winEnd` and a pop in the same cycle. Expect no drop and rptOvf=0 on the new entry.
- `pwmIn` constant high for 70000 cycles. Expect rptHigh=0xFFFF (saturated) and the pulse length saturated at 0xFFF on the falling transition.
- Assert nRst mid-window with one report buffered. Expect rptValid=0 immediately. After release, the first report has rptSeq=0 and counts only post-reset cycles.
